// File: rtl/axi_frame_reader_pkg.sv
// Shared constants and FSM encoding for the AXI framebuffer reader.
// Bursts are fixed INCR16 of 64-bit beats; pixels are 32 bits.
package axi_frame_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  localparam int unsigned BURST_BEATS = 16;
  localparam int unsigned BURST_BYTES = 128;
  localparam int unsigned PIX_BYTES   = 4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a free-entry count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic [AW:0]       free_o
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DepthC = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  always_comb begin
    count   = wptr_q - rptr_q;
    empty_o = (count == '0);
    free_o  = DepthC - count;
    do_pop  = pop_i && !empty_o;
    do_push = push_i && ((count != DepthC) || do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/axi_frame_reader.sv
// Streams a linear framebuffer from AXI memory as 32-bit AXI-Stream pixels,
// issuing one INCR16 burst at a time whenever the beat FIFO has room for it.
module axi_frame_reader
  import axi_frame_reader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       FRAME_W    = 1920,
  parameter int unsigned       FRAME_H    = 1080,
  parameter logic [ADDR_W-1:0] ADDR_START = 32'h1000_0000,
  parameter int unsigned       FIFO_DEPTH = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic              rresp_err
);

  localparam int unsigned NumBursts = FRAME_W * FRAME_H * PIX_BYTES / BURST_BYTES;
  localparam logic [ADDR_W-1:0] LastAddr =
      ADDR_START + ADDR_W'((NumBursts - 1) * BURST_BYTES);
  localparam int unsigned FreeW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned XW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned YW    = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [XW-1:0] XLast = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] YLast = YW'(FRAME_H - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rresp_err_q, rresp_err_d;
  logic              half_q, half_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;

  logic              fifo_push, fifo_pop, fifo_empty, axis_hs;
  logic [DATA_W-1:0] fifo_rdata;
  logic [FreeW-1:0]  fifo_free;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 4'(BURST_BEATS - 1);
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  assign rresp_err     = rresp_err_q;

  // Burst FSM: the address only moves once a burst has fully returned.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rresp_err_d   = rresp_err_q;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    fifo_push     = 1'b0;
    frame_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (fifo_free >= FreeW'(BURST_BEATS))) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = StData;
        end
      end
      StData: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          fifo_push = 1'b1;
          if (m_axi_rresp != 2'b00) begin
            rresp_err_d = 1'b1;
          end
          if (m_axi_rlast) begin
            state_d = StIdle;
            if (addr_q == LastAddr) begin
              addr_d     = ADDR_START;
              frame_done = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_W'(BURST_BYTES);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .push_i  (fifo_push),
    .wdata_i (m_axi_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .free_o  (fifo_free)
  );

  // Unpacker: low pixel, then high pixel, then release the beat.
  always_comb begin
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = half_q ? fifo_rdata[DATA_W-1 -: 32] : fifo_rdata[31:0];
    m_axis_tuser  = m_axis_tvalid && (x_q == '0) && (y_q == '0);
    m_axis_tlast  = m_axis_tvalid && (x_q == XLast);
    axis_hs       = m_axis_tvalid && m_axis_tready;
    fifo_pop      = axis_hs && half_q;
    half_d        = axis_hs ? !half_q : half_q;
    x_d           = x_q;
    y_d           = y_q;
    if (axis_hs) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      addr_q      <= ADDR_START;
      rresp_err_q <= 1'b0;
      half_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rresp_err_q <= rresp_err_d;
      half_q      <= half_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

endmodule

// File: tb/tb_axi_frame_reader.sv
// Bench for axi_frame_reader: a small AXI slave and an AXIS sink run alongside
// a directed sequence; pixels are checked against a queue of expected words.
module tb_axi_frame_reader;

  localparam int unsigned W = 32;
  localparam int unsigned H = 2;
  localparam logic [31:0] START = 32'h1000_0000;

  logic        aclk, aresetn, enable;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic        frame_done, rresp_err;

  axi_frame_reader #(
    .ADDR_W     (32),
    .DATA_W     (64),
    .FRAME_W    (W),
    .FRAME_H    (H),
    .ADDR_START (START),
    .FIFO_DEPTH (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .rresp_err     (rresp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: expected pixels in order, and counters since reset.
  logic [31:0] exp_q[$];
  int pix_cnt    = 0;
  int ar_idx     = 0;
  int ar_cnt     = 0;
  int slave_beat = -1;
  bit slave_busy = 0;
  bit hold_tready = 0;
  int ar_delay   = 0;
  int err_beat   = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // AXI read slave: drives on negedges so every handshake is decided at the next posedge.
  initial begin : slave
    logic [31:0] a0;
    logic [63:0] beat;
    int burst;
    int gap;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    forever begin
      @(negedge aclk);
      if (aresetn && m_axi_arvalid) begin
        slave_busy = 1'b1;
        slave_beat = -1;
        a0 = m_axi_araddr;
        for (int d = 0; d < ar_delay; d++) begin
          @(negedge aclk);
          if (!aresetn) break;
          check("ar_hold_valid", m_axi_arvalid, 1);
          check("ar_hold_addr", m_axi_araddr, a0);
        end
        if (!aresetn) begin
          slave_busy = 1'b0;
          continue;
        end
        burst = ar_idx;
        check("ar_addr", a0, START + 32'((burst % 2) * 128));
        check("ar_fields", {m_axi_arlen, m_axi_arsize, m_axi_arburst}, 9'b1111_011_01);
        m_axi_arready = 1'b1;
        @(negedge aclk);
        m_axi_arready = 1'b0;
        if (!aresetn) begin
          slave_busy = 1'b0;
          continue;
        end
        ar_idx++;
        ar_cnt++;
        for (int b = 0; b < 16; b++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) @(negedge aclk);
          if (!aresetn) break;
          beat = (b == 0 && burst % 2 == 0) ? 64'hBBBBBBBB_AAAAAAAA
                                            : {$urandom(), $urandom()};
          m_axi_rdata  = beat;
          m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (b == 15);
          m_axi_rvalid = 1'b1;
          slave_beat   = b;
          #1;
          check("r_ready", m_axi_rready, 1);
          if (b == 15) check("frame_done", frame_done, (burst % 2 == 1));
          @(negedge aclk);
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
          if (!aresetn) break;
          exp_q.push_back(beat[31:0]);
          exp_q.push_back(beat[63:32]);
        end
        err_beat   = -1;
        slave_busy = 1'b0;
      end
    end
  end

  // AXIS sink: random or held-off tready, checks order, sideband and stability.
  initial begin : sink
    bit          prev_stall;
    logic [33:0] prev_word;
    logic [31:0] e;
    prev_stall    = 1'b0;
    prev_word     = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      m_axis_tready = hold_tready ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      if (!aresetn) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("axis_hold_valid", m_axis_tvalid, 1);
        check("axis_hold_word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_word);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("axis_pixel_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("axis_tdata", m_axis_tdata, e);
          check("axis_tuser", m_axis_tuser, (pix_cnt % (W * H)) == 0);
          check("axis_tlast", m_axis_tlast, (pix_cnt % W) == W - 1);
          pix_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic wait_ars(input int target);
    int t = 0;
    while (ar_cnt < target && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("wait_ar_timeout", ar_cnt >= target, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    int quiet = 0;
    while (quiet < 20 && t < 4000) begin
      @(negedge aclk);
      #2;
      t++;
      if (!slave_busy && exp_q.size() == 0 && !m_axi_arvalid) quiet++;
      else quiet = 0;
    end
    check("drain_timeout", quiet, 20);
  endtask

  task automatic check_reset();
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rresp_err", rresp_err, 0);
    check("rst_araddr", m_axi_araddr, START);
  endtask

  initial begin : main
    int base;
    int t;
    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_reset();
    @(negedge aclk);
    aresetn = 1'b1;

    // Frame wrap and stop/resume with retained address.
    enable = 1'b1;
    wait_ars(3);
    enable = 1'b0;
    wait_drain();
    check("stop_ar_count", ar_cnt, 3);
    check("stop_arvalid", m_axi_arvalid, 0);
    check("stop_araddr", m_axi_araddr, START + 32'h80);
    check("pix_count_a", pix_cnt, ar_idx * 32);
    check("no_err_a", rresp_err, 0);
    enable = 1'b1;
    wait_ars(4);
    enable = 1'b0;
    wait_drain();
    check("wrap_araddr", m_axi_araddr, START);

    // Sink backpressure: FIFO fills after two bursts and blocks further reads.
    base = ar_cnt;
    hold_tready = 1'b1;
    enable = 1'b1;
    repeat (200) @(negedge aclk);
    #2;
    check("full_ar_count", ar_cnt, base + 2);
    check("full_arvalid", m_axi_arvalid, 0);
    check("full_tvalid", m_axis_tvalid, 1);
    hold_tready = 1'b0;
    wait_ars(base + 3);
    enable = 1'b0;
    wait_drain();
    check("pix_count_b", pix_cnt, ar_idx * 32);

    // Slow arready and an error response on one beat.
    ar_delay = 5;
    err_beat = 3;
    base = ar_cnt;
    enable = 1'b1;
    wait_ars(base + 1);
    enable = 1'b0;
    wait_drain();
    check("err_set", rresp_err, 1);
    check("pix_count_c", pix_cnt, ar_idx * 32);
    ar_delay = 0;
    enable = 1'b1;
    wait_ars(base + 2);
    enable = 1'b0;
    wait_drain();
    check("err_sticky", rresp_err, 1);

    // Reset in the middle of a data phase.
    enable = 1'b1;
    t = 0;
    while (!(slave_busy && slave_beat >= 5) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("mid_burst_reached", slave_beat >= 5, 1);
    #2;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_reset();
    exp_q.delete();
    pix_cnt = 0;
    ar_idx  = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    base = ar_cnt;
    wait_ars(base + 1);
    t = 0;
    while (pix_cnt < 1 && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("post_reset_pixel", pix_cnt >= 1, 1);
    enable = 1'b0;
    wait_drain();
    check("pix_count_d", pix_cnt, ar_idx * 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
